// File: rtl/aoc_jtag_pkg.sv
// Shared types and constants for the JTAG direction receiver.
// Holds the move encoding, the ASCII bytes it decodes, and the byte decoder.
package aoc_jtag_pkg;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_S = 2'd1,
      DIR_W = 2'd2,
      DIR_E = 2'd3
   } dir_t;

   localparam logic [7:0] CHAR_UP    = 8'h5E;
   localparam logic [7:0] CHAR_DOWN  = 8'h76;
   localparam logic [7:0] CHAR_LEFT  = 8'h3C;
   localparam logic [7:0] CHAR_RIGHT = 8'h3E;
   localparam logic [7:0] CHAR_LF    = 8'h0A;
   localparam int         BYTE_BITS  = 8;

   typedef struct packed {
      logic vld;
      dir_t dir;
   } dec_t;

   // Map an ASCII byte to a move; vld=0 for anything that is not an arrow.
   function automatic dec_t decode_byte(input logic [7:0] b);
      dec_t d;
      d.vld = 1'b1;
      d.dir = DIR_N;
      case (b)
         CHAR_UP:    d.dir = DIR_N;
         CHAR_DOWN:  d.dir = DIR_S;
         CHAR_LEFT:  d.dir = DIR_W;
         CHAR_RIGHT: d.dir = DIR_E;
         default:    d.vld = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/jtag_dir_receiver_dir_fifo.sv
// Small synchronous FIFO of moves between the JTAG byte decoder and the solver.
// A push on a full FIFO is dropped and latches a sticky overflow flag, unless
// a pop happens in the same cycle, in which case both proceed.
module dir_fifo
   import aoc_jtag_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3
) (
   input  logic tck,
   input  logic rst_n,
   input  logic i_push,
   input  dir_t i_push_dir,
   input  logic i_pop,
   output dir_t o_dir,
   output logic o_full,
   output logic o_empty,
   output logic o_overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   dir_t                  r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_overflow;
   logic                  w_pop;
   logic                  w_push_ok;

   assign o_empty    = (r_count == '0);
   assign o_full     = (r_count == (DEPTH_LOG2+1)'(DEPTH));
   assign w_pop      = i_pop & ~o_empty;
   assign w_push_ok  = i_push & (~o_full | w_pop);
   assign o_dir      = o_empty ? DIR_N : r_mem[r_rd_ptr];
   assign o_overflow = r_overflow;

   // Storage array; contents are only observed through o_dir when non-empty.
   always_ff @(posedge tck) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dir;
   end

   // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (i_push & ~w_push_ok) r_overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/jtag_dir_receiver.sv
// JTAG USER4 front end: deserialises LSB-first 8-bit DR scans into bytes,
// decodes arrow characters into moves queued for the solver, tracks the
// end-of-input marker and shifts the solver result back out on tdo.
// Optional feature macro: JTAG_RX_BYTE_COUNT_EN adds a saturating count of
// committed bytes, reported in the upper 16 bits of the readback while no
// final result is available.
module jtag_dir_receiver
   import aoc_jtag_pkg::*;
#(
   parameter int RESULT_WIDTH    = 32,
   parameter int FIFO_DEPTH_LOG2 = 3
) (
   input  logic                    tck,
   input  logic                    rst_n,
   input  logic                    tdi,
   output logic                    tdo,
   input  logic                    test_logic_reset,
   input  logic                    ir_is_user,
   input  logic                    capture_dr,
   input  logic                    shift_dr,
   input  logic                    update_dr,
   output logic                    dir_valid,
   input  logic                    dir_ready,
   output dir_t                    dir,
   output logic                    end_of_input,
   input  logic [RESULT_WIDTH-1:0] result,
   input  logic                    result_valid,
   output logic                    overflow
);

   logic [BYTE_BITS-1:0]    r_byte_sr;
   logic [3:0]              r_bit_cnt;
   logic [RESULT_WIDTH-1:0] r_rd_sr;
   logic                    r_eoi_seen;
   logic                    r_eoi;
   logic                    w_capture;
   logic                    w_shift;
   logic                    w_commit;
   logic                    w_push;
   logic                    w_empty;
   logic                    w_full;
   dec_t                    w_dec;
   logic [RESULT_WIDTH-1:0] w_capture_val;

   assign w_capture = ir_is_user & capture_dr;
   assign w_shift   = ir_is_user & shift_dr;
   // Only an exact 8-bit scan commits; readbacks saturate bit_cnt at 15.
   assign w_commit  = ir_is_user & update_dr & (r_bit_cnt == 4'(BYTE_BITS));
   assign w_dec     = decode_byte(r_byte_sr);
   assign w_push    = w_commit & w_dec.vld;

`ifdef JTAG_RX_BYTE_COUNT_EN
   logic [15:0] r_byte_cnt;

   // Saturating count of committed bytes for host-side progress polling.
   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n)                               r_byte_cnt <= '0;
      else if (w_commit && r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 1'b1;
   end

   assign w_capture_val = result_valid ? result
                                       : {r_byte_cnt, {(RESULT_WIDTH-16){1'b0}}};
`else
   assign w_capture_val = result_valid ? result : '0;
`endif

   // Byte deserialiser; Test-Logic-Reset drops a partial byte but nothing else.
   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         r_byte_sr <= '0;
         r_bit_cnt <= '0;
      end else if (test_logic_reset) begin
         r_byte_sr <= '0;
         r_bit_cnt <= '0;
      end else if (w_capture) begin
         r_bit_cnt <= '0;
      end else if (w_shift) begin
         r_byte_sr <= {tdi, r_byte_sr[BYTE_BITS-1:1]};
         if (r_bit_cnt != 4'd15) r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   // Readback shift register: loaded on capture, shifted LSB-first on tdo.
   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n)         r_rd_sr <= '0;
      else if (w_capture) r_rd_sr <= w_capture_val;
      else if (w_shift)   r_rd_sr <= {tdi, r_rd_sr[RESULT_WIDTH-1:1]};
   end

   // End-of-input: newline seen, reported once the queue has drained.
   always_ff @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         r_eoi_seen <= 1'b0;
         r_eoi      <= 1'b0;
      end else begin
         if (w_commit && r_byte_sr == CHAR_LF) r_eoi_seen <= 1'b1;
         r_eoi <= r_eoi_seen & w_empty;
      end
   end

   dir_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .tck        (tck),
      .rst_n      (rst_n),
      .i_push     (w_push),
      .i_push_dir (w_dec.dir),
      .i_pop      (dir_ready),
      .o_dir      (dir),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_overflow (overflow)
   );

   assign tdo          = r_rd_sr[0];
   assign dir_valid    = ~w_empty;
   assign end_of_input = r_eoi;

endmodule

// File: tb/tb_jtag_dir_receiver.sv
// Bench for jtag_dir_receiver: directed scenarios plus randomized scans,
// checked every cycle against a queue-based model of the receiver.
module tb_jtag_dir_receiver;
   import aoc_jtag_pkg::*;

   logic        tck = 1'b0;
   logic        rst_n = 1'b0;
   logic        tdi = 1'b0;
   logic        tdo;
   logic        test_logic_reset = 1'b0;
   logic        ir_is_user = 1'b0;
   logic        capture_dr = 1'b0;
   logic        shift_dr = 1'b0;
   logic        update_dr = 1'b0;
   logic        dir_valid;
   logic        dir_ready = 1'b0;
   dir_t        dir;
   logic        end_of_input;
   logic [31:0] result = '0;
   logic        result_valid = 1'b0;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   jtag_dir_receiver #(.RESULT_WIDTH(32), .FIFO_DEPTH_LOG2(3)) dut (
      .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo),
      .test_logic_reset(test_logic_reset), .ir_is_user(ir_is_user),
      .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
      .dir_valid(dir_valid), .dir_ready(dir_ready), .dir(dir),
      .end_of_input(end_of_input), .result(result),
      .result_valid(result_valid), .overflow(overflow)
   );

   always #5 tck = ~tck;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [1:0] m_q[$];      // queued moves
   logic       m_bits[$];   // tdi bits shifted since the last capture/TLR
   logic       m_rdq[$];    // readback register contents, element 0 on tdo
   logic       m_eoi_seen, m_eoi, m_ovf;
   int         m_cnt;       // committed bytes
   logic [1:0] popped[$];   // moves the DUT handed over (dir_valid & dir_ready)

   task automatic mdl_reset();
      m_q.delete(); m_bits.delete(); m_rdq.delete();
      for (int i = 0; i < 32; i++) m_rdq.push_back(1'b0);
      m_eoi_seen = 0; m_eoi = 0; m_ovf = 0; m_cnt = 0;
   endtask

   initial mdl_reset();

   task automatic mdl_step(input logic ir, cap, sh, upd, tlr, ti, rdy,
                           input logic [31:0] res, input logic rv);
      logic        pop, eoi_next, commit;
      logic [7:0]  b;
      logic [31:0] v;
      pop      = (m_q.size() != 0) && rdy;
      eoi_next = m_eoi_seen && (m_q.size() == 0);
      commit   = ir && upd && (m_bits.size() == 8);
      b = '0;
      if (commit) for (int i = 0; i < 8; i++) b[i] = m_bits[i];
      // readback register
      if (ir && cap) begin
`ifdef JTAG_RX_BYTE_COUNT_EN
         v = rv ? res : (32'(m_cnt) << 16);
`else
         v = rv ? res : 32'd0;
`endif
         m_rdq.delete();
         for (int i = 0; i < 32; i++) m_rdq.push_back(v[i]);
      end else if (ir && sh) begin
         void'(m_rdq.pop_front());
         m_rdq.push_back(ti);
      end
      // move queue
      if (pop) void'(m_q.pop_front());
      if (commit) begin
         if (m_cnt < 65535) m_cnt++;
         if (b == 8'h0A) m_eoi_seen = 1;
         if (b == 8'h5E || b == 8'h76 || b == 8'h3C || b == 8'h3E) begin
            if (m_q.size() < 8)
               m_q.push_back(b == 8'h5E ? 2'd0 : b == 8'h76 ? 2'd1 : b == 8'h3C ? 2'd2 : 2'd3);
            else
               m_ovf = 1;
         end
      end
      m_eoi = eoi_next;
      // byte bit history
      if (tlr || (ir && cap)) m_bits.delete();
      else if (ir && sh && m_bits.size() < 16) m_bits.push_back(ti);
   endtask

   // Model advance and per-cycle comparison
   always @(posedge tck) begin
      logic s_ir, s_cap, s_sh, s_upd, s_tlr, s_tdi, s_rdy, s_rv, s_rst;
      logic [31:0] s_res;
      s_ir = ir_is_user; s_cap = capture_dr; s_sh = shift_dr; s_upd = update_dr;
      s_tlr = test_logic_reset; s_tdi = tdi; s_rdy = dir_ready; s_rv = result_valid;
      s_res = result; s_rst = rst_n;
      if (s_rst && dir_valid && dir_ready) popped.push_back(dir);
      if (!s_rst) mdl_reset();
      else mdl_step(s_ir, s_cap, s_sh, s_upd, s_tlr, s_tdi, s_rdy, s_res, s_rv);
      #1;
      chk("tdo", 32'(tdo), 32'(m_rdq[0]));
      chk("dir_valid", 32'(dir_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("dir", 32'(dir), 32'(m_q[0]));
      chk("end_of_input", 32'(end_of_input), 32'(m_eoi));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   end

   // ---------------- stimulus ----------------
   logic       rdy_rand = 0;
   logic       snap_tdo, snap_valid;
   logic [1:0] snap_dir;

   // One TAP cycle: snapshot outputs, then drive the next state's controls.
   task automatic step(input logic p_ir, p_cap, p_sh, p_upd, p_tlr, p_tdi);
      @(negedge tck);
      snap_tdo = tdo; snap_valid = dir_valid; snap_dir = dir;
      ir_is_user = p_ir; capture_dr = p_cap; shift_dr = p_sh;
      update_dr = p_upd; test_logic_reset = p_tlr; tdi = p_tdi;
      if (rdy_rand) dir_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge tck);
      rst_n = 0;
      idle(2);
      @(negedge tck);
      rst_n = 1;
   endtask

   // Capture, n shifts of b LSB-first, Exit1, Update, then one idle cycle.
   task automatic scan_byte(input logic [15:0] b, input int n, input logic ir);
      step(ir, 1, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) step(ir, 0, 1, 0, 0, b[i]);
      step(ir, 0, 0, 0, 0, 0);
      step(ir, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic readback(output logic [31:0] got);
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         step(1, 0, 1, 0, 0, 0);
         got[i] = snap_tdo;
      end
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
   endtask

   logic [7:0] tbl [7] = '{8'h5E, 8'h76, 8'h3C, 8'h3E, 8'h0A, 8'h78, 8'h5E};

   initial begin
      logic [31:0] got;
      logic [31:0] exp_rb;
      idle(2);
      // reset state
      chk("rst_tdo", 32'(tdo), 0);
      chk("rst_valid", 32'(dir_valid), 0);
      chk("rst_dir", 32'(dir), 32'(DIR_N));
      chk("rst_eoi", 32'(end_of_input), 0);
      chk("rst_ovf", 32'(overflow), 0);
      @(negedge tck); rst_n = 1;

      // '^' with dir_ready=0: visible one tck after update_dr
      dir_ready = 0;
      scan_byte(16'h5E, 8, 1);
      chk("t1_valid", 32'(snap_valid), 1);
      chk("t1_dir", 32'(snap_dir), 32'(DIR_N));

      // ">>v<" then '\n', consumer always ready
      do_reset();
      dir_ready = 1;
      popped.delete();
      scan_byte(16'h3E, 8, 1); scan_byte(16'h3E, 8, 1);
      scan_byte(16'h76, 8, 1); scan_byte(16'h3C, 8, 1);
      scan_byte(16'h0A, 8, 1);
      for (int i = 0; i < 20 && !end_of_input; i++) idle(1);
      chk("t2_eoi", 32'(end_of_input), 1);
      chk("t2_npop", popped.size(), 4);
      if (popped.size() == 4) begin
         chk("t2_pop0", 32'(popped[0]), 32'(DIR_E));
         chk("t2_pop1", 32'(popped[1]), 32'(DIR_E));
         chk("t2_pop2", 32'(popped[2]), 32'(DIR_S));
         chk("t2_pop3", 32'(popped[3]), 32'(DIR_W));
      end
      chk("t2_ovf", 32'(overflow), 0);

      // 9 x '^' with no consumer: 8 queued, 9th dropped
      do_reset();
      dir_ready = 0;
      for (int i = 0; i < 8; i++) scan_byte(16'h5E, 8, 1);
      chk("t3_ovf_before", 32'(overflow), 0);
      scan_byte(16'h5E, 8, 1);
      chk("t3_ovf", 32'(overflow), 1);
      popped.delete();
      dir_ready = 1;
      idle(12);
      dir_ready = 0;
      chk("t3_npop", popped.size(), 8);
      foreach (popped[i]) chk("t3_popN", 32'(popped[i]), 32'(DIR_N));
      chk("t3_ovf_sticky", 32'(overflow), 1);

      // readback with final result; queued move must survive
      do_reset();
      scan_byte(16'h5E, 8, 1);
      result = 32'h0000_0004; result_valid = 1;
      readback(got);
      chk("t4_readback", got, 32'h4);
      chk("t4_fifo_kept", 32'(dir_valid), 1);
      // readback without a result
      result_valid = 0;
      readback(got);
`ifdef JTAG_RX_BYTE_COUNT_EN
      exp_rb = 32'h0001_0000;
`else
      exp_rb = 32'h0;
`endif
      chk("t5_readback", got, exp_rb);

      // 'x' then a 7-bit '^', then reset mid-shift
      do_reset();
      scan_byte(16'h78, 8, 1);
      chk("t6_x_ignored", 32'(dir_valid), 0);
      scan_byte(16'h5E, 7, 1);
      chk("t6_short_ignored", 32'(dir_valid), 0);
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 1'(8'h5E >> i));
      rst_n = 0;
      #1;
      chk("t6_tdo", 32'(tdo), 0);
      chk("t6_valid", 32'(dir_valid), 0);
      chk("t6_dir", 32'(dir), 32'(DIR_N));
      chk("t6_eoi", 32'(end_of_input), 0);
      chk("t6_ovf", 32'(overflow), 0);
      idle(2);
      @(negedge tck); rst_n = 1;

      // randomized traffic
      rdy_rand = 1;
      for (int n = 0; n < 200; n++) begin
         int k;
         k = $urandom_range(0, 9);
         if ($urandom_range(0, 39) == 0) do_reset();
         case (k)
            0, 1, 2, 3, 4: scan_byte(16'(tbl[$urandom_range(0, 6)]), 8, 1);
            5: scan_byte(16'($urandom), $urandom_range(0, 1) ? 7 : 9, 1);
            6: begin
               result = $urandom; result_valid = 1'($urandom_range(0, 1));
               readback(got);
            end
            7: scan_byte(16'(tbl[$urandom_range(0, 3)]), 8, 0);
            8: begin
               logic [7:0] b;
               b = tbl[$urandom_range(0, 4)];
               step(1, 1, 0, 0, 0, 0);
               for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 1'($urandom_range(0, 1)));
               step(0, 0, 0, 0, 1, 0);
               for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, b[i]);
               step(1, 0, 0, 0, 0, 0);
               step(1, 0, 0, 1, 0, 0);
               step(0, 0, 0, 0, 0, 0);
            end
            default: idle($urandom_range(1, 4));
         endcase
      end
      rdy_rand = 0;
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
